// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding requests to imem and
// feeds an enable-less IF/ID register, holding outputs stable under stall via a skid buffer.
module fetch_unit #(
  parameter int unsigned    ADDR_W   = 32,
  parameter int unsigned    INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  output logic               flush_o
);

  typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    pc_r;
  logic [ADDR_W-1:0]    drop_addr_r;
  logic                 valid_r;
  logic [INSTR_W-1:0]   buf_instr;
  logic [ADDR_W-1:0]    buf_pc4;
  logic                 buf_v;
  logic [ADDR_W-1:0]    pc_inc;
  logic                 consume;

  assign pc_inc  = pc_r + ADDR_W'(4);
  assign consume = valid_r & ~stall_i;
  assign flush_o = ~valid_r | redirect_i;

  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    if (!rst_i) begin
      unique case (state_q)
        StFetch: begin
          imem_req_o  = 1'b1;
          imem_addr_o = pc_r;
        end
        StDrop: begin
          imem_req_o  = 1'b1;
          imem_addr_o = drop_addr_r;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StFetch;
      pc_r        <= RESET_PC;
      drop_addr_r <= '0;
      valid_r     <= 1'b0;
      instr_o     <= '0;
      pc_plus4_o  <= '0;
      buf_instr   <= '0;
      buf_pc4     <= '0;
      buf_v       <= 1'b0;
    end else if (redirect_i) begin
      // Redirect outranks stall and ack; an in-flight request must still be drained.
      pc_r    <= redirect_pc_i;
      valid_r <= 1'b0;
      buf_v   <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (!imem_ack_i) begin
            drop_addr_r <= pc_r;
            state_q     <= StDrop;
          end
        end
        StDrop:  if (imem_ack_i) state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ack_i) begin
            pc_r <= pc_inc;
            if (!valid_r || consume) begin
              instr_o    <= imem_data_i;
              pc_plus4_o <= pc_inc;
              valid_r    <= 1'b1;
            end else begin
              buf_instr <= imem_data_i;
              buf_pc4   <= pc_inc;
              buf_v     <= 1'b1;
              state_q   <= StHold;
            end
          end else if (consume) begin
            valid_r <= 1'b0;
          end
        end
        StHold: begin
          if (consume && buf_v) begin
            instr_o    <= buf_instr;
            pc_plus4_o <= buf_pc4;
            buf_v      <= 1'b0;
            state_q    <= StFetch;
          end
        end
        StDrop:  if (imem_ack_i) state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule
